// File: rtl/quad_enc_gen_pkg.sv
// Shared definitions for the quadrature encoder generator and its receiver.
// Holds the phase type, generator state encoding and the phase-to-{A,B} map.
package quad_enc_pkg;

  localparam int DEFAULT_COUNTS_PER_REV = 8192;

  typedef logic [1:0] phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  // Gray sequence so that forward stepping makes A lead B.
  function automatic logic [1:0] phase_to_ab(input phase_t ph);
    logic [1:0] ab;
    case (ph)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      2'd3:    ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/quad_enc_gen_step_timer.sv
// Loadable down-counter producing a step strobe when the count reaches one.
// A load always takes priority over the running decrement.
module quad_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                i_en,
  input  logic                i_load,
  input  logic [PERIOD_W-1:0] i_load_val,
  output logic                o_step
);

  logic [PERIOD_W-1:0] r_count;

  // Tick counter: load, else count down while enabled and not yet at zero.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_count <= {PERIOD_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != {PERIOD_W{1'b0}})) begin
      r_count <= r_count - PERIOD_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_step = i_en && (r_count == PERIOD_W'(1));

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: emits A/B/index from a commanded step period and
// direction, with a single-entry command slot that is consumed on step edges.
module quad_enc_gen
  import quad_enc_pkg::*;
#(
  parameter int COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV,
  parameter int COUNT_SIZE     = 13,
  parameter int PERIOD_W       = 16
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PERIOD_W-1:0]   cmd_period,
  input  logic                  cmd_dir,
  input  logic                  cmd_run,
  input  logic                  home,
  output logic                  enc_a,
  output logic                  enc_b,
  output logic                  enc_i,
  output logic [COUNT_SIZE-1:0] position,
  output logic                  step_pulse,
  output logic                  running
);

  gen_state_t            r_state;
  logic                  r_running;
  logic                  r_pend_valid;
  logic [PERIOD_W-1:0]   r_pend_period;
  logic                  r_pend_dir;
  logic                  r_pend_run;
  logic [PERIOD_W-1:0]   r_active_period;
  logic                  r_active_dir;
  phase_t                r_phase;
  logic [COUNT_SIZE-1:0] r_position;
  logic                  r_enc_a;
  logic                  r_enc_b;
  logic                  r_enc_i;
  logic                  r_step_pulse;

  logic                  w_accept;
  logic                  w_step_edge;
  logic                  w_apply_idle;
  logic                  w_apply_pend;
  logic                  w_apply;
  logic [PERIOD_W-1:0]   w_app_period;
  logic                  w_app_dir;
  logic                  w_app_run;
  logic                  w_load;
  logic [PERIOD_W-1:0]   w_load_val;
  phase_t                w_phase_nxt;
  logic [COUNT_SIZE-1:0] w_pos_nxt;

  assign w_accept     = cmd_valid && !r_pend_valid;
  assign w_apply_idle = (r_state == IDLE) && w_accept;
  assign w_apply_pend = w_step_edge && r_pend_valid;
  assign w_apply      = w_apply_idle || w_apply_pend;
  assign w_load       = w_apply || w_step_edge || home;

  // Command source: the slot when draining at a step edge, else the live port.
  always_comb begin
    w_app_period = cmd_period;
    w_app_dir    = cmd_dir;
    w_app_run    = cmd_run;
    if (w_apply_pend) begin
      w_app_period = r_pend_period;
      w_app_dir    = r_pend_dir;
      w_app_run    = r_pend_run;
    end else begin
      w_app_period = cmd_period;
      w_app_dir    = cmd_dir;
      w_app_run    = cmd_run;
    end
    w_load_val = w_apply ? w_app_period : r_active_period;
  end

  // Next phase/position for a step in the active direction, with revolution wrap.
  always_comb begin
    w_pos_nxt   = r_position;
    w_phase_nxt = r_phase;
    if (r_active_dir) begin
      w_phase_nxt = r_phase + 2'd1;
      if (r_position == COUNT_SIZE'(COUNTS_PER_REV - 1)) begin
        w_pos_nxt = {COUNT_SIZE{1'b0}};
      end else begin
        w_pos_nxt = r_position + COUNT_SIZE'(1);
      end
    end else begin
      w_phase_nxt = r_phase - 2'd1;
      if (r_position == {COUNT_SIZE{1'b0}}) begin
        w_pos_nxt = COUNT_SIZE'(COUNTS_PER_REV - 1);
      end else begin
        w_pos_nxt = r_position - COUNT_SIZE'(1);
      end
    end
  end

  quad_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .sclk       (sclk),
    .rstn       (rstn),
    .i_en       (r_state == RUN),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_step     (w_step_edge)
  );

  // Generator FSM and command slot.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= IDLE;
      r_running       <= 1'b0;
      r_pend_valid    <= 1'b0;
      r_pend_period   <= {PERIOD_W{1'b0}};
      r_pend_dir      <= 1'b0;
      r_pend_run      <= 1'b0;
      r_active_period <= {PERIOD_W{1'b0}};
      r_active_dir    <= 1'b0;
    end else begin
      if (w_apply) begin
        r_active_period <= w_app_period;
        r_active_dir    <= w_app_dir;
        if (w_app_run && (w_app_period != {PERIOD_W{1'b0}})) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end else begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      end
      case (r_state)
        IDLE: r_pend_valid <= 1'b0;
        RUN: begin
          if (w_apply_pend) begin
            r_pend_valid <= 1'b0;
          end else if (w_accept) begin
            r_pend_valid  <= 1'b1;
            r_pend_period <= cmd_period;
            r_pend_dir    <= cmd_dir;
            r_pend_run    <= cmd_run;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_running    <= 1'b0;
          r_pend_valid <= 1'b0;
        end
      endcase
    end
  end

  // Phase, position and pin outputs; home overrides a coincident step.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_phase      <= 2'd0;
      r_position   <= {COUNT_SIZE{1'b0}};
      r_enc_a      <= 1'b0;
      r_enc_b      <= 1'b0;
      r_enc_i      <= 1'b1;
      r_step_pulse <= 1'b0;
    end else if (home) begin
      r_phase      <= 2'd0;
      r_position   <= {COUNT_SIZE{1'b0}};
      r_enc_a      <= 1'b0;
      r_enc_b      <= 1'b0;
      r_enc_i      <= 1'b1;
      r_step_pulse <= 1'b0;
    end else if (w_step_edge) begin
      r_phase            <= w_phase_nxt;
      r_position         <= w_pos_nxt;
      {r_enc_a, r_enc_b} <= phase_to_ab(w_phase_nxt);
      r_enc_i            <= (w_pos_nxt == {COUNT_SIZE{1'b0}});
      r_step_pulse       <= 1'b1;
    end else begin
      r_step_pulse <= 1'b0;
    end
  end

  assign cmd_ready  = !r_pend_valid;
  assign enc_a      = r_enc_a;
  assign enc_b      = r_enc_b;
  assign enc_i      = r_enc_i;
  assign position   = r_position;
  assign step_pulse = r_step_pulse;
  assign running    = r_running;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Bench for quad_enc_gen: event-time reference model plus a 4X decoder fed
// from the generated A/B pins, driven by directed and random commands.
`timescale 1ns/1ps
module tb_quad_enc_gen;

  localparam int CPR = 8192;
  localparam int CS  = 13;
  localparam int PW  = 16;

  logic          sclk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic          cmd_run = 1'b0;
  logic          home = 1'b0;
  logic [PW-1:0] cmd_period = '0;
  logic          cmd_ready, enc_a, enc_b, enc_i, step_pulse, running;
  logic [CS-1:0] position;

  always #5 sclk = ~sclk;

  quad_enc_gen #(.COUNTS_PER_REV(CPR), .COUNT_SIZE(CS), .PERIOD_W(PW)) dut (
    .sclk(sclk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_dir(cmd_dir), .cmd_run(cmd_run), .home(home),
    .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i), .position(position),
    .step_pulse(step_pulse), .running(running)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: absolute edge index of the next step, position as an integer.
  int cyc = 0;
  int m_pos, m_phase, m_period, m_next, p_period;
  bit m_dir, m_run, m_pend_v, m_pulse, p_dir, p_run, last_acc;
  int dec_cnt, dec_prev, dec_err;
  logic [1:0] ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  logic [18:0] obs;
  assign obs = {position, enc_a, enc_b, enc_i, step_pulse, running, cmd_ready};

  localparam logic [18:0] RESET_VEC = {13'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  function automatic logic [18:0] exp_vec();
    return {CS'(m_pos), ab_tbl[m_phase], 1'(m_pos == 0), m_pulse, m_run, !m_pend_v};
  endfunction

  function automatic int gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_phase = 0; m_period = 0; m_next = -1;
    m_dir = 0; m_run = 0; m_pend_v = 0; m_pulse = 0;
    dec_cnt = 0; dec_prev = 0;
  endtask

  task automatic apply(input int p, input bit d, input bit r);
    m_period = p; m_dir = d; m_run = r && (p != 0); m_next = cyc + p;
  endtask

  task automatic tick();
    bit acc, stepe, hm;
    int idx;
    acc   = cmd_valid && !m_pend_v;
    stepe = m_run && (m_next == cyc);
    hm    = home;
    m_pulse = stepe && !hm;
    if (m_pulse) begin
      m_pos   = m_dir ? (m_pos + 1) % CPR : (m_pos + CPR - 1) % CPR;
      m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
    end
    if (hm) begin m_pos = 0; m_phase = 0; end
    if (stepe && m_pend_v) begin
      apply(p_period, p_dir, p_run);
      m_pend_v = 0;
    end else if (!m_run && acc) begin
      apply(int'(cmd_period), cmd_dir, cmd_run);
    end else begin
      if (m_run && acc) begin
        m_pend_v = 1; p_period = int'(cmd_period); p_dir = cmd_dir; p_run = cmd_run;
      end
      if (m_run && (stepe || hm)) m_next = cyc + m_period;
    end
    last_acc = acc;
    @(posedge sclk);
    @(negedge sclk);
    cyc++;
    idx = gray_idx({enc_a, enc_b});
    if (hm) dec_cnt = 0;
    else begin
      case ((idx - dec_prev + 4) % 4)
        1: dec_cnt = (dec_cnt + 1) % CPR;
        3: dec_cnt = (dec_cnt + CPR - 1) % CPR;
        2: dec_err++;
        default: ;
      endcase
    end
    dec_prev = idx;
  endtask

  task automatic send_cmd(input int p, input bit d, input bit r);
    cmd_period = PW'(p); cmd_dir = d; cmd_run = r; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_acc) break;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!last_acc) begin n_err++; $display("FAIL send_cmd accept timeout got=0 exp=1"); end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge sclk);
    n_cmp++;
    if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, RESET_VEC); end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_forward();
    int npulse = 0;
    send_cmd(4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (step_pulse) npulse++;
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL fwd cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    n_cmp++;
    if (npulse != 4 || position !== 13'd4) begin
      n_err++; $display("FAIL fwd_count got pulses=%0d pos=%0d exp pulses=4 pos=4", npulse, position);
    end
  endtask

  task automatic test_reverse();
    send_cmd(0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && running; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL stop cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    home = 1'b1; tick(); home = 1'b0;
    n_cmp++;
    if (obs !== exp_vec()) begin n_err++; $display("FAIL rev_home got=%h exp=%h", obs, exp_vec()); end
    send_cmd(2, 1'b0, 1'b1);
    tick(); tick();
    n_cmp++;
    if (position !== 13'd8191 || {enc_a, enc_b} !== 2'b01 || enc_i !== 1'b0) begin
      n_err++; $display("FAIL rev_first got pos=%0d ab=%b i=%b exp pos=8191 ab=01 i=0", position, {enc_a, enc_b}, enc_i);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec() || dec_cnt != m_pos) begin
        n_err++; $display("FAIL rev cyc=%0d got=%h dec=%0d exp=%h pos=%0d", cyc, obs, dec_cnt, exp_vec(), m_pos);
      end
    end
  endtask

  task automatic test_wrap();
    int ihigh = 0;
    send_cmd(0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && running; i++) tick();
    home = 1'b1; tick(); home = 1'b0;
    send_cmd(1, 1'b0, 1'b1);
    send_cmd(0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (position !== 13'd8190 || running !== 1'b0) begin
      n_err++; $display("FAIL wrap_start got pos=%0d run=%b exp pos=8190 run=0", position, running);
    end
    send_cmd(4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (enc_i) ihigh++;
      n_cmp++;
      if (obs !== exp_vec() || dec_cnt != m_pos) begin
        n_err++; $display("FAIL wrap cyc=%0d got=%h dec=%0d exp=%h pos=%0d", cyc, obs, dec_cnt, exp_vec(), m_pos);
      end
    end
    n_cmp++;
    if (ihigh != 4 || position !== 13'd2) begin
      n_err++; $display("FAIL wrap_index got ihigh=%0d pos=%0d exp ihigh=4 pos=2", ihigh, position);
    end
  endtask

  task automatic test_midrun();
    int stall = 0;
    cmd_period = 16'd2; cmd_dir = 1'b1; cmd_run = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL mid_a cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (last_acc) break;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready got=%b exp=0", cmd_ready); end
    cmd_period = 16'd3; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL mid_b cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (last_acc) break;
      stall++;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!last_acc || stall < 1 || stall > 4) begin
      n_err++; $display("FAIL mid_stall got stall=%0d acc=%b exp stall=1..4 acc=1", stall, last_acc);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL mid_c cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    cmd_period = 16'd5; cmd_run = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && running; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL mid_stop cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    n_cmp++;
    if (running !== 1'b0) begin n_err++; $display("FAIL mid_idle got=%b exp=0", running); end
  endtask

  task automatic test_home_step();
    bit found = 0;
    send_cmd(4, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (m_next == cyc) begin found = 1; break; end
      tick();
    end
    home = 1'b1; tick(); home = 1'b0;
    n_cmp++;
    if (!found || step_pulse !== 1'b0 || position !== 13'd0 || {enc_a, enc_b} !== 2'b00 || obs !== exp_vec()) begin
      n_err++; $display("FAIL home_step got=%h found=%b exp=%h", obs, found, exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL home_after cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_period = 16'd1; cmd_dir = 1'b0; cmd_run = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (obs !== RESET_VEC) begin n_err++; $display("FAIL rst_async got=%h exp=%h", obs, RESET_VEC); end
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rst_after cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!cmd_valid || last_acc) begin
        cmd_valid  = ($urandom_range(0, 3) == 0);
        cmd_period = ($urandom_range(0, 9) == 0) ? 16'd0 : PW'($urandom_range(1, 5));
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_run    = ($urandom_range(0, 4) != 0);
      end
      home = ($urandom_range(0, 39) == 0);
      tick();
      n_cmp++;
      if (obs !== exp_vec() || dec_cnt != m_pos) begin
        n_err++; $display("FAIL rand cyc=%0d got=%h dec=%0d exp=%h pos=%0d", cyc, obs, dec_cnt, exp_vec(), m_pos);
      end
    end
    cmd_valid = 1'b0; home = 1'b0;
    n_cmp++;
    if (dec_err != 0) begin n_err++; $display("FAIL dec_jumps got=%0d exp=0", dec_err); end
  endtask

  initial begin
    dec_err = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_wrap();
    test_midrun();
    test_home_step();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
